hazard_ctrl: RTL

- Parametrised pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W). Replaces the hard-tied en=1 on pc_reg and the pipeline registers.
- Keeps a shadow pipeline of destination/source register tags. From it, generates:
  - forwarding selects for the Execute-stage operands;
  - load-use stalls;
  - branch/jump flushes;
  - a multi-cycle data-memory wait.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_if.sv | 47 ++++
 rtl/hazard_fwd_unit.sv | 31 +++
 rtl/hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the 5-stage RV32I hazard controller.
//   fwd_sel_t   : Execute-operand forwarding select encoding
//   stage_tag_t : per-stage shadow tag (valid, regWrite, isLoad, rd)
//   tag_match() : "this stage will write register rs" test used by both the
//                 forwarding units and the load-use detector
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int HZ_REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                         valid;
        logic                         regWrite;
        logic                         isLoad;
        logic [HZ_REG_ADDR_WIDTH-1:0] rd;
    } stage_tag_t;

    localparam stage_tag_t STAGE_BUBBLE = '0;

    // x0 is hard-wired to zero in RV32I, so a write to it must never be
    // treated as a producer for a later reader of x0.
    function automatic logic tag_match(input stage_tag_t                   tag,
                                       input logic [HZ_REG_ADDR_WIDTH-1:0] rs);
        return tag.valid && tag.regWrite && (tag.rd != '0) && (tag.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if
// Bundle between the core datapath and the hazard controller.
//   Decode inputs : validD_i, rsD_i, usesRsD_i, rdD_i, regWriteD_i, isLoadD_i
//   Execute input : pcSrcE_i
//   Outputs       : stallF_o, stallD_o, stallE_o, stallM_o,
//                   flushD_o, flushE_o, flushW_o, fwdSelE_o
// master = datapath side (drives the Decode/Execute info, reads controls)
// slave  = hazard_ctrl side
// ---------------------------------------------------------------------------
interface hazard_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
    parameter int NUM_SRC        = 2
);

    logic                                validD_i;
    logic [NUM_SRC*REG_ADDR_WIDTH-1:0]   rsD_i;
    logic [NUM_SRC-1:0]                  usesRsD_i;
    logic [REG_ADDR_WIDTH-1:0]           rdD_i;
    logic                                regWriteD_i;
    logic                                isLoadD_i;
    logic                                pcSrcE_i;

    logic                                stallF_o;
    logic                                stallD_o;
    logic                                stallE_o;
    logic                                stallM_o;
    logic                                flushD_o;
    logic                                flushE_o;
    logic                                flushW_o;
    logic [NUM_SRC*2-1:0]                fwdSelE_o;

    modport master (
        output validD_i, rsD_i, usesRsD_i, rdD_i, regWriteD_i, isLoadD_i, pcSrcE_i,
        input  stallF_o, stallD_o, stallE_o, stallM_o,
               flushD_o, flushE_o, flushW_o, fwdSelE_o
    );

    modport slave (
        input  validD_i, rsD_i, usesRsD_i, rdD_i, regWriteD_i, isLoadD_i, pcSrcE_i,
        output stallF_o, stallD_o, stallE_o, stallM_o,
               flushD_o, flushE_o, flushW_o, fwdSelE_o
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one Execute-stage source operand.
//   rs_i     : operand register index held in the E shadow stage
//   m_tag_i  : Memory-stage shadow tag
//   w_tag_i  : Writeback-stage shadow tag
//   sel_o    : FWD_M (ALUResult in M), FWD_W (Result in W) or FWD_RF
// ---------------------------------------------------------------------------
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [HZ_REG_ADDR_WIDTH-1:0] rs_i,
    input  stage_tag_t                   m_tag_i,
    input  stage_tag_t                   w_tag_i,
    output fwd_sel_t                     sel_o
);

    // The youngest producer wins, so M is checked before W. A load sitting in
    // M has no data yet (its ALUResult is only the address), so it is skipped
    // here; the load-use stall guarantees the consumer reaches E only once the
    // load has moved on to W.
    always_comb begin
        sel_o = FWD_RF;
        if (tag_match(m_tag_i, rs_i) && !m_tag_i.isLoad) begin
            sel_o = FWD_M;
        end else if (tag_match(w_tag_i, rs_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
// Keeps a shadow pipeline of register tags for E/M/W and produces the
// forwarding selects, load-use stall, branch/jump flush and multi-cycle
// data-memory wait.
//   clk_i : clock
//   rst_i : synchronous, active-high reset
//   hz    : hazard_if slave port (Decode/Execute info in, stall/flush/fwd out)
// Parameters:
//   REG_ADDR_WIDTH : register index width (must equal HZ_REG_ADDR_WIDTH)
//   NUM_SRC        : number of source operands tracked and forwarded
//   MEM_LATENCY    : cycles a load occupies the Memory stage
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
    parameter int NUM_SRC        = 2,
    parameter int MEM_LATENCY    = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    hazard_if.slave   hz
);

    stage_tag_t                               e_q, e_d;
    stage_tag_t                               m_q, m_d;
    stage_tag_t                               w_q, w_d;
    logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]   rs_e_q, rs_e_d;

    logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]   rs_d;
    stage_tag_t                               d_tag;

    logic                                     src_hit;
    logic                                     load_use;
    logic                                     ctrl_hazard;
    logic                                     mem_wait;

    logic                                     stall_f;
    logic                                     stall_d;
    logic                                     stall_e;
    logic                                     stall_m;
    logic                                     flush_d;
    logic                                     flush_e;
    logic                                     flush_w;

    fwd_sel_t                                 fwd_sel [NUM_SRC];
    logic [NUM_SRC*2-1:0]                     fwd_vec;

    assign rs_d = hz.rsD_i;

    // Decode-stage tag as it would enter the E shadow stage.
    always_comb begin
        d_tag          = STAGE_BUBBLE;
        d_tag.valid    = hz.validD_i;
        d_tag.regWrite = hz.regWriteD_i;
        d_tag.isLoad   = hz.isLoadD_i;
        d_tag.rd       = hz.rdD_i;
    end

    // Load-use: the Decode instruction actually reads a register that the
    // load currently in E is going to write. Unused operand slots may carry
    // garbage indices, so each slot is qualified by its uses bit.
    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (hz.usesRsD_i[k] && tag_match(e_q, rs_d[k])) begin
                src_hit = 1'b1;
            end
        end
    end

    assign load_use    = hz.validD_i && e_q.isLoad && src_hit;
    assign ctrl_hazard = hz.pcSrcE_i && e_q.valid;

    // Multi-cycle memory: a load in M freezes everything up to and including
    // M for MEM_LATENCY-1 cycles, feeding bubbles into W meanwhile. The counter
    // only exists when memory is actually slower than one cycle.
    generate
        if (MEM_LATENCY > 1) begin : g_mem_wait
            localparam int WAIT_W = $clog2(MEM_LATENCY);
            localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);

            logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

            assign mem_wait = m_q.valid && m_q.isLoad && (wait_cnt_q < WAIT_LAST);

            // Count wait cycles while stalled; drop back to zero the cycle the
            // load is finally allowed to leave M.
            always_comb begin
                wait_cnt_d = '0;
                if (mem_wait) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            // Wait counter register; cleared by reset so no stall survives it.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end
        end else begin : g_no_mem_wait
            assign mem_wait = 1'b0;
        end
    endgenerate

    // Hazard priority. The memory wait freezes E, so a branch resolved there
    // is simply held and acted on once the wait ends. A taken branch discards
    // the Decode instruction, so any load-use stall it would have caused is
    // moot and only the flushes are raised.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (ctrl_hazard) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Shadow pipeline advance, mirroring exactly what the real pipeline
    // registers do with the stall/flush controls issued this cycle. Bubbles
    // also clear the E source indices so they cannot trigger forwarding.
    always_comb begin
        w_d    = flush_w ? STAGE_BUBBLE : m_q;
        m_d    = stall_m ? m_q : e_q;
        e_d    = e_q;
        rs_e_d = rs_e_q;
        if (!stall_e) begin
            if (flush_e) begin
                e_d    = STAGE_BUBBLE;
                rs_e_d = '0;
            end else begin
                e_d       = d_tag;
                e_d.valid = hz.validD_i && !flush_d;
                rs_e_d    = rs_d;
            end
        end
    end

    // Shadow stage registers; reset wipes every tag so nothing forwards or
    // stalls on instructions that were in flight before reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_q    <= STAGE_BUBBLE;
            m_q    <= STAGE_BUBBLE;
            w_q    <= STAGE_BUBBLE;
            rs_e_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            rs_e_q <= rs_e_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
            fwd_unit u_fwd (
                .rs_i    (rs_e_q[k]),
                .m_tag_i (m_q),
                .w_tag_i (w_q),
                .sel_o   (fwd_sel[k])
            );
        end
    endgenerate

    // Pack per-operand selects: operand k occupies bits [k*2 +: 2].
    always_comb begin
        fwd_vec = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            fwd_vec[k*2 +: 2] = fwd_sel[k];
        end
    end

    // Outputs are forced low while reset is asserted, since the shadow state
    // only clears at the next edge.
    assign hz.stallF_o  = stall_f && !rst_i;
    assign hz.stallD_o  = stall_d && !rst_i;
    assign hz.stallE_o  = stall_e && !rst_i;
    assign hz.stallM_o  = stall_m && !rst_i;
    assign hz.flushD_o  = flush_d && !rst_i;
    assign hz.flushE_o  = flush_e && !rst_i;
    assign hz.flushW_o  = flush_w && !rst_i;
    assign hz.fwdSelE_o = rst_i ? '0 : fwd_vec;

endmodule
